// File: rtl/seven_seg_scanner_pkg.sv
// Shared types for the multiplexed seven-segment scanner: FSM state encoding,
// segment pattern type and the polarity helper used on the cathode drivers.
package seven_seg_scanner_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_LIT   = 2'd2,
        ST_DARK  = 2'd3
    } scan_state_t;

    typedef logic [7:0] seg_pattern_t;

    // Number of brightness steps the on-window is divided into.
    localparam int BRIGHT_LEVELS = 16;

    // Maps an active-high pattern onto the physical cathode level; dark when not lit.
    function automatic seg_pattern_t seg_drive(
        input seg_pattern_t pattern,
        input logic         lit,
        input logic         active_low
    );
        seg_pattern_t level;
        if (lit) begin
            level = pattern;
        end else begin
            level = 8'h00;
        end
        if (active_low) begin
            return ~level;
        end else begin
            return level;
        end
    endfunction

endpackage

// File: rtl/seven_seg_scanner_slot_timer.sv
// Slot timer: owns the in-slot cycle counter and digit index and produces
// registered slot-start / frame-start strobes for the cycle with cnt == 0.
module scan_slot_timer
    import seven_seg_scanner_pkg::*;
#(
    parameter int SLOT_CYCLES = 100000,
    parameter int NUM_DIGITS  = 6,
    parameter int CNT_W       = 17,
    parameter int DIG_W       = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run_next,
    output logic [CNT_W-1:0] cnt,
    output logic [DIG_W-1:0] digit,
    output logic             slot_start,
    output logic             frame_start,
    output logic             slot_last
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLOT_CYCLES - 1);
    localparam logic [DIG_W-1:0] DIG_LAST = DIG_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [DIG_W-1:0] DIG_ZERO = {DIG_W{1'b0}};

    logic             run_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [DIG_W-1:0] digit_q;
    logic [DIG_W-1:0] digit_d;
    logic             slot_start_q;
    logic             slot_start_d;
    logic             frame_start_q;
    logic             frame_start_d;

    // Counting only resumes after a running cycle, so a fresh start always sits at cnt 0 / digit 0.
    always_comb begin
        cnt_d   = CNT_ZERO;
        digit_d = DIG_ZERO;
        if (run_next && run_q) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d = CNT_ZERO;
                if (digit_q == DIG_LAST) begin
                    digit_d = DIG_ZERO;
                end else begin
                    digit_d = digit_q + DIG_W'(1);
                end
            end else begin
                cnt_d   = cnt_q + CNT_W'(1);
                digit_d = digit_q;
            end
        end else begin
            cnt_d   = CNT_ZERO;
            digit_d = DIG_ZERO;
        end
        slot_start_d  = run_next && (cnt_d == CNT_ZERO);
        frame_start_d = slot_start_d && (digit_d == DIG_ZERO);
    end

    // Counter, digit index and strobe registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            run_q         <= 1'b0;
            cnt_q         <= CNT_ZERO;
            digit_q       <= DIG_ZERO;
            slot_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            run_q         <= run_next;
            cnt_q         <= cnt_d;
            digit_q       <= digit_d;
            slot_start_q  <= slot_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign cnt         = cnt_q;
    assign digit       = digit_q;
    assign slot_start  = slot_start_q;
    assign frame_start = frame_start_q;
    assign slot_last   = (cnt_q == CNT_LAST);

endmodule

// File: rtl/seven_seg_scanner.sv
// Multiplexed seven-segment scanner with anti-ghost blanking, 16-step
// brightness and a per-frame shadow of the segment patterns.
module seven_seg_scanner
    import seven_seg_scanner_pkg::*;
#(
    parameter int NUM_DIGITS       = 6,
    parameter int SLOT_CYCLES      = 100000,
    parameter int BLANK_CYCLES     = 1000,
    parameter bit ANODE_ACTIVE_LOW = 1'b1,
    parameter bit SEG_ACTIVE_LOW   = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ena,
    input  logic [NUM_DIGITS-1:0][7:0] segs_in,
    input  logic [3:0]                 brightness,
    output logic [NUM_DIGITS-1:0]      anodes,
    output logic [7:0]                 cathodes,
    output logic                       frame_tick
);

    localparam int ON_WINDOW = SLOT_CYCLES - BLANK_CYCLES;
    localparam int UNIT      = ON_WINDOW / BRIGHT_LEVELS;
    localparam int CNT_W     = $clog2(SLOT_CYCLES);
    localparam int DIG_W     = $clog2(NUM_DIGITS);

    localparam logic [CNT_W-1:0]      BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [NUM_DIGITS-1:0] ANODES_OFF = {NUM_DIGITS{ANODE_ACTIVE_LOW}};
    localparam logic [7:0]            SEGS_OFF   = {8{SEG_ACTIVE_LOW}};

    // The brightness latch is taken in the first blank cycle, so blanking may not be empty.
    if (ON_WINDOW <= 0 || (ON_WINDOW % BRIGHT_LEVELS) != 0) begin : g_bad_window
        $error("seven_seg_scanner: SLOT_CYCLES-BLANK_CYCLES must be positive and a multiple of 16");
    end
    if (BLANK_CYCLES < 1) begin : g_bad_blank
        $error("seven_seg_scanner: BLANK_CYCLES must be at least 1");
    end
    if (NUM_DIGITS < 2) begin : g_bad_digits
        $error("seven_seg_scanner: NUM_DIGITS must be at least 2");
    end

    scan_state_t                 state_q;
    scan_state_t                 state_d;
    logic                        run_next_s;
    logic [CNT_W-1:0]            cnt_s;
    logic [DIG_W-1:0]            digit_s;
    logic                        slot_start_s;
    logic                        frame_start_s;
    logic                        slot_last_s;
    logic [CNT_W-1:0]            lit_last_s;
    logic                        lit_s;
    logic [NUM_DIGITS-1:0]       onehot_s;
    logic [3:0]                  bright_q;
    logic [3:0]                  bright_d;
    logic [NUM_DIGITS-1:0][7:0]  shadow_q;
    logic [NUM_DIGITS-1:0][7:0]  shadow_d;
    logic [NUM_DIGITS-1:0]       anodes_q;
    logic [NUM_DIGITS-1:0]       anodes_d;
    seg_pattern_t                cathodes_q;
    seg_pattern_t                cathodes_d;

    scan_slot_timer #(
        .SLOT_CYCLES (SLOT_CYCLES),
        .NUM_DIGITS  (NUM_DIGITS),
        .CNT_W       (CNT_W),
        .DIG_W       (DIG_W)
    ) u_timer (
        .clk         (clk),
        .rst         (rst),
        .run_next    (run_next_s),
        .cnt         (cnt_s),
        .digit       (digit_s),
        .slot_start  (slot_start_s),
        .frame_start (frame_start_s),
        .slot_last   (slot_last_s)
    );

    // Last lit cycle of the slot for the brightness latched at its start.
    always_comb begin
        lit_last_s = BLANK_LAST + CNT_W'(UNIT) * (CNT_W'(bright_q) + CNT_W'(1));
    end

    // Scan FSM; slot wrap is tested first so full brightness runs straight into the next blank.
    always_comb begin
        state_d = state_q;
        if (!ena) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_BLANK;
                end
                ST_BLANK: begin
                    if (cnt_s == BLANK_LAST) begin
                        state_d = ST_LIT;
                    end else begin
                        state_d = ST_BLANK;
                    end
                end
                ST_LIT: begin
                    if (slot_last_s) begin
                        state_d = ST_BLANK;
                    end else if (cnt_s == lit_last_s) begin
                        state_d = ST_DARK;
                    end else begin
                        state_d = ST_LIT;
                    end
                end
                ST_DARK: begin
                    if (slot_last_s) begin
                        state_d = ST_BLANK;
                    end else begin
                        state_d = ST_DARK;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
        run_next_s = (state_d != ST_IDLE);
    end

    // Brightness per slot and a frame-wide shadow so a digit never tears mid-frame.
    always_comb begin
        if (slot_start_s) begin
            bright_d = brightness;
        end else begin
            bright_d = bright_q;
        end
        if (frame_start_s) begin
            shadow_d = segs_in;
        end else begin
            shadow_d = shadow_q;
        end
    end

    // Output drive; ena gates it so dropping ena darkens the display on the very next edge.
    always_comb begin
        lit_s    = ena && (state_q == ST_LIT);
        onehot_s = {NUM_DIGITS{1'b0}};
        if (lit_s) begin
            onehot_s[digit_s] = 1'b1;
        end else begin
            onehot_s = {NUM_DIGITS{1'b0}};
        end
        if (ANODE_ACTIVE_LOW) begin
            anodes_d = ~onehot_s;
        end else begin
            anodes_d = onehot_s;
        end
        cathodes_d = seg_drive(shadow_q[digit_s], lit_s, SEG_ACTIVE_LOW);
    end

    // State, brightness latch, shadow and registered pad drivers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            bright_q   <= 4'd0;
            shadow_q   <= {(NUM_DIGITS * 8){1'b0}};
            anodes_q   <= ANODES_OFF;
            cathodes_q <= SEGS_OFF;
        end else begin
            state_q    <= state_d;
            bright_q   <= bright_d;
            shadow_q   <= shadow_d;
            anodes_q   <= anodes_d;
            cathodes_q <= cathodes_d;
        end
    end

    assign anodes     = anodes_q;
    assign cathodes   = cathodes_q;
    assign frame_tick = frame_start_s;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Scoreboard bench: a time-since-enable reference model predicts every output
// cycle, a separate monitor compares them and the at-most-one-anode invariant.
module tb_seven_seg_scanner;

    localparam int ND    = 6;
    localparam int SLOT  = 36;
    localparam int BLANK = 4;
    localparam int UNIT  = (SLOT - BLANK) / 16;
    localparam int FRAME = SLOT * ND;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 ena = 1'b0;
    logic [ND-1:0][7:0]   segs = '0;
    logic [3:0]           brightness = 4'd0;
    logic [ND-1:0]        anodes;
    logic [7:0]           cathodes;
    logic                 frame_tick;

    typedef struct packed {
        logic [ND-1:0] an;
        logic [7:0]    ca;
        logic          tick;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    // Reference model: running flag, cycles since the scan started, slot brightness, frame shadow.
    bit         m_run = 1'b0;
    int         m_t   = 0;
    int         m_b   = 0;
    logic [7:0] m_sh [ND];

    seven_seg_scanner #(
        .NUM_DIGITS       (ND),
        .SLOT_CYCLES      (SLOT),
        .BLANK_CYCLES     (BLANK),
        .ANODE_ACTIVE_LOW (1'b1),
        .SEG_ACTIVE_LOW   (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .segs_in    (segs),
        .brightness (brightness),
        .anodes     (anodes),
        .cathodes   (cathodes),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    // Called right after each rising edge with the inputs that edge sampled.
    task automatic step_model();
        exp_t e;
        int   c;
        int   d;
        c    = m_t % SLOT;
        d    = (m_t / SLOT) % ND;
        e.an = {ND{1'b1}};
        e.ca = 8'hFF;
        if (!rst && ena && m_run && c >= BLANK && c < BLANK + (m_b + 1) * UNIT) begin
            e.an[d] = 1'b0;
            e.ca    = ~m_sh[d];
        end
        if (m_run && c == 0) begin
            m_b = int'(brightness);
            if (d == 0) begin
                for (int i = 0; i < ND; i++) m_sh[i] = segs[i];
            end
        end
        if (rst) begin
            m_run = 1'b0;
            m_t   = 0;
            for (int i = 0; i < ND; i++) m_sh[i] = 8'h00;
        end else if (!ena) begin
            m_run = 1'b0;
            m_t   = 0;
        end else if (!m_run) begin
            m_run = 1'b1;
            m_t   = 0;
        end else begin
            m_t = m_t + 1;
        end
        e.tick = m_run && (m_t % FRAME == 0);
        exp_q.push_back(e);
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            step_model();
            cyc = cyc + 1;
            #1;
        end
    endtask

    task automatic run_until(input int dig, input int cnt, input int budget);
        int k;
        k = 0;
        while (!(m_run && (m_t % SLOT) == cnt && ((m_t / SLOT) % ND) == dig) && k < budget) begin
            cycles(1);
            k = k + 1;
        end
        total = total + 1;
        if (!(m_run && (m_t % SLOT) == cnt && ((m_t / SLOT) % ND) == dig)) begin
            bad = bad + 1;
            $display("FAIL run_until: digit %0d cnt %0d not reached within %0d cycles", dig, cnt, budget);
        end
    endtask

    // Monitor: pops one prediction per output cycle, independent of the stimulus flow.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total = total + 1;
                if (anodes !== e.an || cathodes !== e.ca || frame_tick !== e.tick) begin
                    bad = bad + 1;
                    $display("FAIL outputs cyc=%0d: got an=%b ca=%h tick=%b, want an=%b ca=%h tick=%b",
                             cyc, anodes, cathodes, frame_tick, e.an, e.ca, e.tick);
                end
                total = total + 1;
                if ($countones(~anodes) > 1 || (anodes === {ND{1'b1}} && cathodes !== 8'hFF)) begin
                    bad = bad + 1;
                    $display("FAIL invariant cyc=%0d: an=%b ca=%h, want <=1 anode low and dark cathodes when none",
                             cyc, anodes, cathodes);
                end
            end
        end
    end

    initial begin
        int r;
        for (int i = 0; i < ND; i++) m_sh[i] = 8'h00;

        // Reset, then full brightness with random patterns.
        cycles(3);
        rst = 1'b0;
        ena = 1'b1;
        brightness = 4'd15;
        for (int i = 0; i < ND; i++) segs[i] = 8'($urandom_range(0, 255));
        cycles(2 * FRAME + 10);

        // Minimum and middle brightness.
        brightness = 4'd0;
        cycles(FRAME);
        brightness = 4'd7;
        cycles(FRAME);

        // Pattern change mid-frame must wait for the next frame.
        brightness = 4'd15;
        segs = '0;
        segs[3] = 8'h3F;
        run_until(5, 0, FRAME + 10);
        run_until(1, 0, FRAME + 10);
        segs[3] = 8'h06;
        cycles(FRAME + 50);

        // Drop enable while digit 2 is lit, then restart.
        run_until(2, 10, FRAME + 10);
        ena = 1'b0;
        cycles(3);
        ena = 1'b1;
        cycles(FRAME + 20);

        // Reset pulse during a lit window.
        run_until(4, 20, FRAME + 10);
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        cycles(FRAME + 20);

        // Randomized traffic: brightness and pattern changes, enable drops, reset pulses.
        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 999);
            rst = 1'b0;
            if (r < 20) begin
                brightness = 4'($urandom_range(0, 15));
            end else if (r < 40) begin
                segs[$urandom_range(0, ND - 1)] = 8'($urandom_range(0, 255));
            end else if (r == 41) begin
                rst = 1'b1;
            end else if (!ena && r < 300) begin
                ena = 1'b1;
            end else if (ena && r >= 993) begin
                ena = 1'b0;
            end
            cycles(1);
        end
        rst = 1'b0;
        ena = 1'b1;
        cycles(FRAME);

        @(negedge clk);
        #1;
        total = total + 1;
        if (exp_q.size() != 0) begin
            bad = bad + 1;
            $display("FAIL drain: %0d predictions left, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seven_seg_scanner.md
SEVEN_SEG_SCANNER -- requirements
Module: seven_seg_scanner

Interface
REQ-001 Parameter NUM_DIGITS, default 6, number of multiplexed digit positions (>=2).
REQ-002 Parameter SLOT_CYCLES, default 100000, clock cycles per digit slot.
REQ-003 Parameter BLANK_CYCLES, default 1000, anti-ghost blanking cycles at the start of each slot.
REQ-004 Parameter ANODE_ACTIVE_LOW, default 1, 1 = anode lines driven 0 when a digit is on.
REQ-005 Parameter SEG_ACTIVE_LOW, default 1, 1 = cathode lines driven 0 when a segment is lit.
REQ-006 clk  input  1  single system clock; all logic on its rising edge.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 ena  input  1  scan enable; low = display dark.
REQ-009 segs_in  input  [NUM_DIGITS-1:0][7:0]  active-high segment patterns per digit, index 0 = rightmost; bit order passed through unchanged.
REQ-010 brightness  input  4  duty level 0..15.
REQ-011 anodes  output  NUM_DIGITS  digit select lines, polarity per ANODE_ACTIVE_LOW.
REQ-012 cathodes  output  8  segment lines, polarity per SEG_ACTIVE_LOW.
REQ-013 frame_tick  output  1  one-cycle pulse at the start of every frame.

Function
REQ-014 ON_WINDOW = SLOT_CYCLES-BLANK_CYCLES shall be >0 and divisible by 16, else elaboration shall fail; UNIT = ON_WINDOW/16.
REQ-015 A slot counter cnt shall run 0..SLOT_CYCLES-1 then wrap to 0, advancing the digit index (0..NUM_DIGITS-1, wrapping NUM_DIGITS-1 -> 0).
REQ-016 State machine states: IDLE, BLANK, LIT, DARK.
REQ-017 IDLE -> BLANK (cnt=0, digit 0) on the first cycle with ena=1 and rst=0.
REQ-018 BLANK while cnt<BLANK_CYCLES; LIT while BLANK_CYCLES<=cnt<BLANK_CYCLES+(b+1)*UNIT; DARK for remaining cnt; slot wrap -> BLANK.
REQ-019 b shall be brightness sampled at cnt=0 of each slot, held for the slot; mid-slot brightness changes take effect next slot.
REQ-020 At cnt=0 of digit 0 a shadow register shall capture all of segs_in; displayed patterns come only from the shadow (no tearing within a frame).
REQ-021 frame_tick shall be 1 for exactly the cycle in which the shadow captures.
REQ-022 In LIT, anodes shall activate only the current digit and cathodes shall drive shadow[digit]; in IDLE, BLANK, DARK all anodes and all cathodes shall be inactive.
REQ-023 anodes and cathodes shall be registered: outputs at edge n+1 reflect state/cnt at edge n (latency 1 cycle); never two anodes active together.
REQ-024 ena=0 in any state: next state IDLE, cnt and digit index cleared, outputs inactive one cycle later; re-enable restarts at digit 0 BLANK with fresh shadow capture and frame_tick.
REQ-025 Brightness 15 shall light the full ON_WINDOW; brightness 0 shall light exactly UNIT cycles.

Reset
REQ-026 rst=1 shall force IDLE, cnt=0, digit index=0, shadow=0, frame_tick=0, all anodes/cathodes inactive at the next edge; rst has priority over ena.
REQ-027 rst asserted mid-slot shall abort the slot with no partial LIT afterwards.

Structure
REQ-028 A shared package shall hold the state enum typedef and the 8-bit segment-pattern typedef.
REQ-029 One sub-module, scan_slot_timer, shall own cnt, digit index and slot-start/frame-start strobes; the FSM, shadow and output registers stay in seven_seg_scanner.

Verification (SLOT_CYCLES=36, BLANK_CYCLES=4, UNIT=2, NUM_DIGITS=6, active-low)
REQ-030 rst then ena=1, brightness=15 -> frame_tick every 216 cycles; each anode low exactly 32 consecutive cycles per frame, starting 5 cycles after its slot start.
REQ-031 brightness=0 -> each anode low exactly 2 cycles per slot; brightness=7 -> exactly 16.
REQ-032 segs_in[3]=8'h3F, others 0; change segs_in[3] to 8'h06 mid-frame -> cathodes=~8'h3F for rest of frame, ~8'h06 from next frame.
REQ-033 ena dropped during digit 2 LIT -> all anodes high next cycle; ena raised -> frame_tick, digit 0 lit first.
REQ-034 rst pulsed during LIT -> all outputs inactive next cycle, frame restarts at digit 0.
REQ-035 Whole run: assertion that at most one anode is active and cathodes are inactive whenever no anode is active.
